k_and_s_mc_control_unit: RTL and testbench

- Parametrised multicycle control unit for the K-and-S processor. It is the full-ISA successor of the basic fetch/decode controller.
- Sequences fetch, IR load, decode/execute and optional memory access for every decoded_instruction_type value.
- Supports configurable RAM wait states, selectable overflow-flag semantics for BOV/BNOV, and a retired-instruction counter.
- Sits between the instruction decoder/flag register and the datapath/RAM.

---
 rtl/k_and_s_pkg.sv | 40 ++++
 rtl/k_and_s_wait_timer.sv | 31 +++
 rtl/k_and_s_mc_control_unit.sv | 176 +++++++++++++++++
 tb/tb_k_and_s_mc_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K-and-S processor control path.
package k_and_s_pkg;

    // Instruction classes produced by the IR decoder. The type is 5 bits wide,
    // so codes 16..31 are unassigned; the controller treats those like NOP.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    // ALU operation codes
    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Multicycle controller states
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_LOAD_IR = 3'd1,
        ST_DECODE  = 3'd2,
        ST_MEM     = 3'd3,
        ST_HALTED  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/k_and_s_wait_timer.sv
// Access-length timer: counts the cycles of one RAM access (fetch or data
// access) and flags the final cycle. While start is held, done rises once the
// count reaches MEM_WAIT_CYCLES; the counter clears on that final cycle so
// back-to-back accesses (MEM followed directly by FETCH) each start from 0.
module k_and_s_wait_timer #(
    parameter int MEM_WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam logic [3:0] LP_LAST = 4'(MEM_WAIT_CYCLES);

    logic [3:0] r_count;

    assign done = start && (r_count == LP_LAST);

    // Advance while an access is in progress, otherwise hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (start && !done) begin
            r_count <= r_count + 4'd1;
        end else begin
            r_count <= '0;
        end
    end

endmodule

// File: rtl/k_and_s_mc_control_unit.sv
// Multicycle control unit for the K-and-S processor: fetch, IR load,
// decode/execute and optional data-memory access, with configurable RAM wait
// states, selectable overflow flag for BOV/BNOV and a retired-instruction count.
module k_and_s_mc_control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 0,
    parameter int OVF_SIGNED      = 1,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic                    instr_done,
    output logic [CNT_W-1:0]        retired_count
);

    localparam bit LP_OVF_SIGNED = (OVF_SIGNED != 0);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic             w_access;
    logic             w_wait_done;
    logic             w_ovf;
    logic             w_taken;
    logic [CNT_W-1:0] r_retired;

    // The timer runs only during the two RAM-facing states
    assign w_access = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_ovf    = LP_OVF_SIGNED ? signed_overflow : unsigned_overflow;

    k_and_s_wait_timer #(
        .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
    ) u_wait_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(w_access),
        .done (w_wait_done)
    );

    // Branch condition evaluation for the decoded instruction
    always_comb begin
        w_taken = 1'b0;
        case (decoded_instruction)
            I_BRANCH: w_taken = 1'b1;
            I_BZERO:  w_taken = zero_op;
            I_BNZERO: w_taken = !zero_op;
            I_BNEG:   w_taken = neg_op;
            I_BNNEG:  w_taken = !neg_op;
            I_BOV:    w_taken = w_ovf;
            I_BNOV:   w_taken = !w_ovf;
            default:  w_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control-strobe decode; everything defaults to inactive
    always_comb begin
        w_state_next     = r_state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_OR;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        instr_done       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                addr_sel = 1'b0;
                if (w_wait_done) begin
                    w_state_next = ST_LOAD_IR;
                end
            end
            ST_LOAD_IR: begin
                ir_enable    = 1'b1;
                pc_enable    = 1'b1;
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_next = ST_FETCH;
                instr_done   = 1'b1;
                case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        write_reg_enable = 1'b1;
                        c_sel            = 1'b1;
                        flags_reg_enable = 1'b1;
                        case (decoded_instruction)
                            I_ADD:   operation = OP_ADD;
                            I_SUB:   operation = OP_SUB;
                            I_AND:   operation = OP_AND;
                            default: operation = OP_OR;
                        endcase
                    end
                    I_MOVE: begin
                        // MOVE passes the source through the ALU without touching flags
                        write_reg_enable = 1'b1;
                        c_sel            = 1'b1;
                        operation        = OP_OR;
                    end
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                        branch    = w_taken;
                        pc_enable = w_taken;
                    end
                    I_LOAD, I_STORE: begin
                        instr_done   = 1'b0;
                        w_state_next = ST_MEM;
                    end
                    I_HALT: begin
                        w_state_next = ST_HALTED;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                // Write strobes only on the last cycle so each access writes once
                if (w_wait_done) begin
                    instr_done   = 1'b1;
                    w_state_next = ST_FETCH;
                    if (decoded_instruction == I_LOAD) begin
                        write_reg_enable = 1'b1;
                        c_sel            = 1'b0;
                    end
                    if (decoded_instruction == I_STORE) begin
                        ram_write_enable = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (instr_done) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired_count = r_retired;

endmodule

// File: tb/tb_k_and_s_mc_control_unit.sv
// Testbench for k_and_s_mc_control_unit. Unit 0: no wait states, unsigned
// overflow for BOV/BNOV, 2-bit counter. Unit 1: two wait states, signed
// overflow, 16-bit counter. Expected behaviour is an output trace per
// instruction built from the instruction's documented cycle sequence.
module tb_k_and_s_mc_control_unit;
    import k_and_s_pkg::*;

    typedef struct packed {
        logic       branch;
        logic       pc_en;
        logic       ir_en;
        logic       wre;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] op;
        logic       flags_en;
        logic       ram_we;
        logic       halt;
        logic       done;
    } ovec_t;

    typedef struct {
        decoded_instruction_type ins;
        logic z, n, uo, so;
        logic taken;
    } br_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    decoded_instruction_type instr [2];
    logic zf [2];
    logic nf [2];
    logic uf [2];
    logic sf [2];
    ovec_t       out_v [2];
    logic [15:0] cnt_v [2];

    logic a_branch, a_pc, a_ir, a_wre, a_asel, a_csel, a_fl, a_rwe, a_halt, a_done;
    logic [1:0] a_op;
    logic [1:0] a_cnt;
    logic b_branch, b_pc, b_ir, b_wre, b_asel, b_csel, b_fl, b_rwe, b_halt, b_done;
    logic [1:0] b_op;
    logic [15:0] b_cnt;

    int    n_pass = 0;
    int    n_total = 0;
    int    mcnt [2];
    ovec_t exp_q[$];
    ovec_t last_dec;
    int    n_addr, n_ramwe, n_wre;

    always #5 clk = ~clk;

    k_and_s_mc_control_unit #(.MEM_WAIT_CYCLES(0), .OVF_SIGNED(0), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr[0]),
        .zero_op(zf[0]), .neg_op(nf[0]), .unsigned_overflow(uf[0]), .signed_overflow(sf[0]),
        .branch(a_branch), .pc_enable(a_pc), .ir_enable(a_ir), .write_reg_enable(a_wre),
        .addr_sel(a_asel), .c_sel(a_csel), .operation(a_op), .flags_reg_enable(a_fl),
        .ram_write_enable(a_rwe), .halt(a_halt), .instr_done(a_done), .retired_count(a_cnt)
    );

    k_and_s_mc_control_unit #(.MEM_WAIT_CYCLES(2), .OVF_SIGNED(1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr[1]),
        .zero_op(zf[1]), .neg_op(nf[1]), .unsigned_overflow(uf[1]), .signed_overflow(sf[1]),
        .branch(b_branch), .pc_enable(b_pc), .ir_enable(b_ir), .write_reg_enable(b_wre),
        .addr_sel(b_asel), .c_sel(b_csel), .operation(b_op), .flags_reg_enable(b_fl),
        .ram_write_enable(b_rwe), .halt(b_halt), .instr_done(b_done), .retired_count(b_cnt)
    );

    assign out_v[0] = {a_branch, a_pc, a_ir, a_wre, a_asel, a_csel, a_op, a_fl, a_rwe, a_halt, a_done};
    assign out_v[1] = {b_branch, b_pc, b_ir, b_wre, b_asel, b_csel, b_op, b_fl, b_rwe, b_halt, b_done};
    assign cnt_v[0] = {14'd0, a_cnt};
    assign cnt_v[1] = b_cnt;

    function automatic int w_of(int u);
        return (u == 0) ? 0 : 2;
    endfunction

    function automatic int mask_of(int u);
        return (u == 0) ? 3 : 65535;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: cycle-by-cycle output trace from FETCH entry to completion
    task automatic build_trace(int u, decoded_instruction_type ins, logic z, logic n, logic uo, logic so);
        ovec_t v;
        int    w = w_of(u);
        logic  ovf = (u == 0) ? uo : so;
        logic  taken;
        exp_q.delete();
        for (int i = 0; i <= w; i++) begin
            v = '0;
            exp_q.push_back(v);
        end
        v = '0; v.ir_en = 1'b1; v.pc_en = 1'b1;
        exp_q.push_back(v);
        v = '0;
        v.done = 1'b1;
        case (ins)
            I_ADD:  begin v.wre = 1; v.c_sel = 1; v.flags_en = 1; v.op = 2'b01; end
            I_SUB:  begin v.wre = 1; v.c_sel = 1; v.flags_en = 1; v.op = 2'b10; end
            I_AND:  begin v.wre = 1; v.c_sel = 1; v.flags_en = 1; v.op = 2'b11; end
            I_OR:   begin v.wre = 1; v.c_sel = 1; v.flags_en = 1; v.op = 2'b00; end
            I_MOVE: begin v.wre = 1; v.c_sel = 1; v.op = 2'b00; end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                taken = (ins == I_BRANCH) || (ins == I_BZERO && z) || (ins == I_BNZERO && !z) ||
                        (ins == I_BNEG && n) || (ins == I_BNNEG && !n) ||
                        (ins == I_BOV && ovf) || (ins == I_BNOV && !ovf);
                v.branch = taken;
                v.pc_en  = taken;
            end
            I_LOAD, I_STORE: begin
                v.done = 1'b0;
                exp_q.push_back(v);
                for (int i = 0; i <= w; i++) begin
                    v = '0;
                    v.addr_sel = 1'b1;
                    if (i == w) begin
                        v.done = 1'b1;
                        if (ins == I_LOAD) v.wre = 1'b1;
                        else v.ram_we = 1'b1;
                    end
                    exp_q.push_back(v);
                end
                return;
            end
            default: begin end
        endcase
        exp_q.push_back(v);
    endtask

    // Apply one instruction starting at FETCH entry and compare every cycle
    task automatic run_instr(int u, decoded_instruction_type ins, logic z, logic n, logic uo, logic so);
        int first_done = -1;
        int w = w_of(u);
        int exp_lat;
        build_trace(u, ins, z, n, uo, so);
        instr[u] = ins; zf[u] = z; nf[u] = n; uf[u] = uo; sf[u] = so;
        n_addr = 0; n_ramwe = 0; n_wre = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check($sformatf("u%0d ins%0d cyc%0d outputs", u, ins, k), 32'(out_v[u]), 32'(exp_q[k]));
            if (out_v[u].done && first_done < 0) first_done = k;
            if (out_v[u].addr_sel) n_addr++;
            if (out_v[u].ram_we) n_ramwe++;
            if (out_v[u].wre) n_wre++;
            if (k == w + 2) last_dec = out_v[u];
            @(posedge clk); #1;
        end
        exp_lat = (ins == I_LOAD || ins == I_STORE) ? 2 * w + 4 : w + 3;
        check($sformatf("u%0d ins%0d latency", u, ins), 32'(first_done + 1), 32'(exp_lat));
        mcnt[u] = (mcnt[u] + 1) % (mask_of(u) + 1);
        check($sformatf("u%0d ins%0d retired_count", u, ins), 32'(cnt_v[u]), 32'(mcnt[u]));
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock edge
    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0; #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d outputs in reset", u), 32'(out_v[u]), 32'd0);
            check($sformatf("u%0d count in reset", u), 32'(cnt_v[u]), 32'd0);
            mcnt[u] = 0;
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic run_random(int u, int count);
        int r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 31);
            if (r == 15) r = 0;
            run_instr(u, decoded_instruction_type'(5'(r)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        br_vec_t tbl [11];
        int      nop_exp [5];
        ovec_t   hv;

        tbl[0]  = '{I_BZERO,  1, 0, 0, 0, 1};
        tbl[1]  = '{I_BZERO,  0, 0, 0, 0, 0};
        tbl[2]  = '{I_BNZERO, 0, 0, 0, 0, 1};
        tbl[3]  = '{I_BNZERO, 1, 0, 0, 0, 0};
        tbl[4]  = '{I_BNEG,   0, 1, 0, 0, 1};
        tbl[5]  = '{I_BNNEG,  0, 1, 0, 0, 0};
        tbl[6]  = '{I_BOV,    0, 0, 0, 1, 0};
        tbl[7]  = '{I_BOV,    0, 0, 1, 0, 1};
        tbl[8]  = '{I_BNOV,   0, 0, 0, 1, 1};
        tbl[9]  = '{I_BRANCH, 0, 0, 0, 0, 1};
        tbl[10] = '{I_ADD,    1, 1, 1, 1, 0};
        nop_exp = '{1, 2, 3, 0, 1};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            instr[u] = I_NOP; zf[u] = 0; nf[u] = 0; uf[u] = 0; sf[u] = 0; mcnt[u] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Unit 0: ADD with no wait states, then counter wrap with 2-bit count
        do_reset();
        run_instr(0, I_ADD, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_instr(0, I_NOP, 0, 0, 0, 0);
            check($sformatf("nop %0d wrap count", i), 32'(cnt_v[0]), 32'(nop_exp[i]));
        end

        // Branch condition table (unsigned overflow selected on unit 0)
        for (int i = 0; i < 11; i++) begin
            run_instr(0, tbl[i].ins, tbl[i].z, tbl[i].n, tbl[i].uo, tbl[i].so);
            check($sformatf("tbl%0d branch", i), 32'(last_dec.branch), 32'(tbl[i].taken));
            check($sformatf("tbl%0d pc_enable", i), 32'(last_dec.pc_en), 32'(tbl[i].taken));
        end

        run_random(0, 40);

        // HALT is sticky for 20 cycles regardless of the decoded value
        run_instr(0, I_HALT, 0, 0, 0, 0);
        hv = '0; hv.halt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr[0] = decoded_instruction_type'(5'($urandom_range(0, 14)));
            @(negedge clk);
            check($sformatf("halted cyc%0d", i), 32'(out_v[0]), 32'(hv));
            @(posedge clk); #1;
        end
        check("halted count frozen", 32'(cnt_v[0]), 32'(mcnt[0]));
        do_reset();
        run_instr(0, I_ADD, 0, 0, 0, 0);

        // Unit 1: two wait states
        do_reset();
        run_instr(1, I_LOAD, 0, 0, 0, 0);
        check("load addr_sel cycles", 32'(n_addr), 32'd3);
        check("load write_reg cycles", 32'(n_wre), 32'd1);
        check("load ram_we cycles", 32'(n_ramwe), 32'd0);
        run_instr(1, I_STORE, 0, 0, 0, 0);
        check("store ram_we cycles", 32'(n_ramwe), 32'd1);
        check("store write_reg cycles", 32'(n_wre), 32'd0);
        run_instr(1, I_BOV, 0, 0, 0, 1);
        check("bov signed taken", 32'(last_dec.branch), 32'd1);

        // Reset in the middle of a STORE's memory access
        instr[1] = I_STORE;
        repeat (6) @(posedge clk);
        #1;
        check("mid-mem addr_sel", 32'(out_v[1].addr_sel), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-mem reset outputs", 32'(out_v[1]), 32'd0);
        check("mid-mem reset count", 32'(cnt_v[1]), 32'd0);
        mcnt[0] = 0; mcnt[1] = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("held reset cyc%0d", i), 32'(out_v[1]), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_instr(1, I_STORE, 0, 0, 0, 0);
        check("store after reset ram_we", 32'(n_ramwe), 32'd1);

        run_random(1, 40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
